fmul_wb_queue: RTL and testbench
================================

Name: fmul_wb_queue

Overview:
- Write-back buffer directly downstream of the single-precision floating-point multiplier.
- Captures each 32-bit product together with its destination FP register tag and queues it in order.
- Drains entries to the FP register-file write port through a valid/ready handshake.
- Exposes a pending-write lookup so the issue stage can stall on read-after-write hazards against queued products.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- TAG_W, 5, width of the destination register tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous discard of all queued entries.
- in_valid  in  1  a multiplier result is presented this cycle.
- in_ready  out  1  the queue can accept an entry this cycle.
- in_y  in  32  product {sign, exp[7:0], mant[22:0]} from the multiplier.
- in_rd  in  TAG_W  destination register tag for in_y.
- wb_valid  out  1  the head entry is presented to the register file.
- wb_ready  in  1  the register-file write port accepts the entry this cycle.
- wb_data  out  32  head entry product.
- wb_rd  out  TAG_W  head entry tag.
- wb_zero  out  1  head entry is ±0, i.e. wb_data[30:0]==0.
- query_rd  in  TAG_W  register tag probed by the issue stage.
- query_hit  out  1  some valid queued entry targets query_rd.
- count  out  log2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rstn=0 at an edge):
  - count=0, wb_valid=0, in_ready=1.
  - wb_data, wb_rd and wb_zero are 0.
  - Read/write pointers are 0.
  - Reset overrides flush, push and pop in the same cycle.
- Storage:
  - Circular buffer of DEPTH entries {y[31:0], rd[TAG_W-1:0]}.
  - Write pointer and read pointer are each log2(DEPTH) bits and wrap modulo DEPTH.
  - count tracks occupancy, range 0..DEPTH.
- Push:
  - A push happens when in_valid && in_ready.
  - The entry is written at the write pointer, which then advances.
  - in_ready = (count != DEPTH). It is combinational from registered state only and never depends on wb_ready.
  - When full, in_ready=0 even if a pop occurs in the same cycle. Upstream holds in_valid/in_y/in_rd stable until in_ready=1.
- Pop:
  - A pop happens when wb_valid && wb_ready. The read pointer then advances.
  - wb_valid = (count != 0).
  - wb_data, wb_rd and wb_zero come combinationally from the head entry (registered storage). There is no combinational path from in_* to wb_*.
  - While wb_valid=1 and wb_ready=0, wb_data and wb_rd stay stable.
- Latency:
  - An entry pushed at edge N into an empty queue is visible at wb_valid/wb_data after edge N (one cycle minimum).
  - Throughput is 1 entry/cycle when the queue is neither full nor empty.
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both pointers advance.
- Order: strictly FIFO. Two entries with the same rd both drain, in push order.
- flush=1 at an edge:
  - count←0 and both pointers←0.
  - Any push or pop in the same cycle is ignored.
  - in_ready stays 1 during flush.
  - Storage contents need not be cleared.
- query_hit:
  - Combinational OR over valid entries of (entry.rd == query_rd).
  - Uses registered state only, so an entry being pushed this cycle is not visible until the next cycle.
  - The head entry being popped this cycle still counts as a hit.
- Data is passed through unmodified. No rounding, normalisation or exception handling happens here; wb_zero is a decode only.
- Signed zero: 32'h80000000 gives wb_zero=1.
- Flushed or empty entries never produce query_hit=1.

Test Plan:
1. Reset then single push: hold rstn=0 for 2 cycles; then push in_y=32'h40C00000 (6.0), in_rd=3 with wb_ready=1 → next cycle wb_valid=1, wb_data=32'h40C00000, wb_rd=3, wb_zero=0; the following cycle count=0 and wb_valid=0.
2. Fill and back-pressure: wb_ready=0, push 5 entries with rd=1..5 → the first 4 are accepted; in_ready=0 at count=4; the 5th is held. Raise wb_ready → drain order rd=1,2,3,4, then the 5th enters and drains as rd=5.
3. Concurrent push/pop across wrap: 20 cycles with in_valid=1 and wb_ready=1, data=i, rd=i mod 32 → count stays at 1; every value appears exactly once, in order; the pointers wrap at least 4 times.
4. Hazard lookup: queue holds rd=7 and rd=9, query_rd=9 → query_hit=1; query_rd=8 → 0. Push rd=8 → query_hit=0 that cycle and 1 the next.
5. Zero and signed zero: push 32'h00000000 and 32'h80000000 → wb_zero=1 for both, with wb_data unchanged. Push 32'h00800000 → wb_zero=0.
6. Flush and reset mid-operation: with 3 entries queued, assert flush together with in_valid=1 → next cycle count=0, wb_valid=0, query_hit=0 for all tags. Refill 2 entries and pull rstn=0 with wb_ready=1 → after that edge count=0, with no wb pop counted at the reset edge.

Source files
------------

// File: rtl/fmul_wb_queue.sv
// Write-back queue between the FP multiplier and the FP register-file write port.
// Holds products in order, drains them by valid/ready, and answers RAW-hazard tag probes.
module fmul_wb_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_y,
    input  logic [TAG_W-1:0]         in_rd,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [31:0]              wb_data,
    output logic [TAG_W-1:0]         wb_rd,
    output logic                     wb_zero,
    input  logic [TAG_W-1:0]         query_rd,
    output logic                     query_hit,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [31:0]      mem_y  [DEPTH];
    logic [TAG_W-1:0] mem_rd [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             push;
    logic             pop;

    assign in_ready = (count != CNT_FULL);
    assign wb_valid = (count != '0);

    // flush wins over any handshake in the same cycle
    assign push = in_valid && in_ready && !flush;
    assign pop  = wb_valid && wb_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            vld   <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (push) begin
                wptr      <= wptr + PW'(1);
                vld[wptr] <= 1'b1;
            end
            if (pop) begin
                rptr      <= rptr + PW'(1);
                vld[rptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; per-slot valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem_y[wptr]  <= in_y;
            mem_rd[wptr] <= in_rd;
        end
    end

    always_comb begin
        wb_data = '0;
        wb_rd   = '0;
        if (wb_valid) begin
            wb_data = mem_y[rptr];
            wb_rd   = mem_rd[rptr];
        end
        wb_zero = wb_valid && (wb_data[30:0] == 31'd0);
    end

    // Registered state only: an entry being pushed this cycle is not yet visible.
    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (mem_rd[i] == query_rd))
                query_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_fmul_wb_queue.sv
// Self-checking bench for fmul_wb_queue: directed scenarios plus a randomized run
// compared against an in-order queue model.
module tb_fmul_wb_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rstn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_y;
    logic [TAG_W-1:0]  in_rd;
    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_data;
    logic [TAG_W-1:0]  wb_rd;
    logic              wb_zero;
    logic [TAG_W-1:0]  query_rd;
    logic              query_hit;
    logic [CW-1:0]     count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]      mq_y  [$];
    logic [TAG_W-1:0] mq_rd [$];

    fmul_wb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_rd(in_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_zero(wb_zero), .query_rd(query_rd), .query_hit(query_hit), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and update the reference queue from the inputs seen at that edge.
    task automatic tick();
        bit          do_push;
        bit          do_pop;
        logic [31:0] dy;
        logic [TAG_W-1:0] dr;
        do_pop  = rstn && !flush && (mq_y.size() != 0) && wb_ready;
        do_push = rstn && !flush && in_valid && (mq_y.size() != DEPTH);
        @(posedge clk);
        if (!rstn || flush) begin
            mq_y.delete();
            mq_rd.delete();
        end else begin
            if (do_pop) begin
                dy = mq_y.pop_front();
                dr = mq_rd.pop_front();
            end
            if (do_push) begin
                mq_y.push_back(in_y);
                mq_rd.push_back(in_rd);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_y = 32'h1234_5678; in_rd = 5'd9;
        wb_ready = 1'b1; query_rd = 5'd0;
        tick();
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0)      begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (wb_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (wb_data !== 32'd0)   begin n_fail++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
        n_checks++; if (wb_rd !== 5'd0)      begin n_fail++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
        n_checks++; if (wb_zero !== 1'b0)    begin n_fail++; $display("FAIL reset_wb_zero got=%b exp=0", wb_zero); end
        rstn = 1'b1;
        in_valid = 1'b1; in_y = 32'h40C0_0000; in_rd = 5'd3; wb_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (wb_valid !== 1'b1)          begin n_fail++; $display("FAIL single_wb_valid got=%b exp=1", wb_valid); end
        n_checks++; if (wb_data !== 32'h40C0_0000)  begin n_fail++; $display("FAIL single_wb_data got=%h exp=40c00000", wb_data); end
        n_checks++; if (wb_rd !== 5'd3)             begin n_fail++; $display("FAIL single_wb_rd got=%0d exp=3", wb_rd); end
        n_checks++; if (wb_zero !== 1'b0)           begin n_fail++; $display("FAIL single_wb_zero got=%b exp=0", wb_zero); end
        tick();
        n_checks++; if (count !== 3'd0)      begin n_fail++; $display("FAIL single_drain_count got=%0d exp=0", count); end
        n_checks++; if (wb_valid !== 1'b0)   begin n_fail++; $display("FAIL single_drain_wb_valid got=%b exp=0", wb_valid); end
    endtask

    task automatic test_fill_backpressure();
        logic [31:0] exp_d [5];
        int k;
        bit acc;
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) exp_d[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_y = exp_d[i]; in_rd = TAG_W'(i + 1);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d] got=%b exp=1", i, in_ready); end
            tick();
        end
        in_y = exp_d[4]; in_rd = 5'd5;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (count !== 3'd4)    begin n_fail++; $display("FAIL full_count got=%0d exp=4", count); end
        tick();
        tick();
        n_checks++; if (count !== 3'd4)    begin n_fail++; $display("FAIL held_count got=%0d exp=4", count); end
        n_checks++; if (wb_rd !== 5'd1)    begin n_fail++; $display("FAIL held_wb_rd got=%0d exp=1", wb_rd); end
        n_checks++; if (wb_data !== exp_d[0]) begin n_fail++; $display("FAIL held_wb_data got=%h exp=%h", wb_data, exp_d[0]); end
        wb_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_in_ready got=%b exp=0", in_ready); end
        k = 0;
        for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
            if (wb_valid) begin
                n_checks++; if (wb_rd !== TAG_W'(k + 1)) begin n_fail++; $display("FAIL drain_rd[%0d] got=%0d exp=%0d", k, wb_rd, k + 1); end
                n_checks++; if (wb_data !== exp_d[k])    begin n_fail++; $display("FAIL drain_data[%0d] got=%h exp=%h", k, wb_data, exp_d[k]); end
                k++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        n_checks++; if (k !== 5)        begin n_fail++; $display("FAIL drain_total got=%0d exp=5", k); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_end_count got=%0d exp=0", count); end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back_wrap();
        wb_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                in_valid = 1'b1; in_y = 32'(i); in_rd = TAG_W'(i % 32);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                n_checks++; if (wb_valid !== 1'b1)          begin n_fail++; $display("FAIL wrap_wb_valid[%0d] got=%b exp=1", i, wb_valid); end
                n_checks++; if (wb_data !== 32'(i - 1))      begin n_fail++; $display("FAIL wrap_data[%0d] got=%0d exp=%0d", i, wb_data, i - 1); end
                n_checks++; if (wb_rd !== TAG_W'((i - 1) % 32)) begin n_fail++; $display("FAIL wrap_rd[%0d] got=%0d exp=%0d", i, wb_rd, i - 1); end
                n_checks++; if (count !== 3'd1)              begin n_fail++; $display("FAIL wrap_count[%0d] got=%0d exp=1", i, count); end
            end
            tick();
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_hazard();
        wb_ready = 1'b0;
        in_valid = 1'b1; in_y = 32'h3F80_0000; in_rd = 5'd7; tick();
        in_y = 32'h4000_0000; in_rd = 5'd9; tick();
        in_valid = 1'b0;
        query_rd = 5'd9; #1;
        n_checks++; if (query_hit !== 1'b1) begin n_fail++; $display("FAIL hit_rd9 got=%b exp=1", query_hit); end
        query_rd = 5'd8; #1;
        n_checks++; if (query_hit !== 1'b0) begin n_fail++; $display("FAIL hit_rd8_absent got=%b exp=0", query_hit); end
        in_valid = 1'b1; in_y = 32'h4040_0000; in_rd = 5'd8; #1;
        n_checks++; if (query_hit !== 1'b0) begin n_fail++; $display("FAIL hit_rd8_pushing got=%b exp=0", query_hit); end
        tick();
        in_valid = 1'b0; #1;
        n_checks++; if (query_hit !== 1'b1) begin n_fail++; $display("FAIL hit_rd8_next got=%b exp=1", query_hit); end
        query_rd = 5'd7; wb_ready = 1'b1; #1;
        n_checks++; if (query_hit !== 1'b1) begin n_fail++; $display("FAIL hit_head_popping got=%b exp=1", query_hit); end
        tick();
        n_checks++; if (query_hit !== 1'b0) begin n_fail++; $display("FAIL hit_after_pop got=%b exp=0", query_hit); end
        tick();
        tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL hazard_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_zero();
        wb_ready = 1'b0;
        in_valid = 1'b1; in_y = 32'h0000_0000; in_rd = 5'd1; tick();
        in_y = 32'h8000_0000; in_rd = 5'd2; tick();
        in_y = 32'h0080_0000; in_rd = 5'd3; tick();
        in_valid = 1'b0; #1;
        n_checks++; if (wb_zero !== 1'b1)           begin n_fail++; $display("FAIL zero_pos_flag got=%b exp=1", wb_zero); end
        n_checks++; if (wb_data !== 32'h0000_0000)  begin n_fail++; $display("FAIL zero_pos_data got=%h exp=00000000", wb_data); end
        wb_ready = 1'b1;
        tick();
        n_checks++; if (wb_zero !== 1'b1)           begin n_fail++; $display("FAIL zero_neg_flag got=%b exp=1", wb_zero); end
        n_checks++; if (wb_data !== 32'h8000_0000)  begin n_fail++; $display("FAIL zero_neg_data got=%h exp=80000000", wb_data); end
        tick();
        n_checks++; if (wb_zero !== 1'b0)           begin n_fail++; $display("FAIL zero_denorm_edge_flag got=%b exp=0", wb_zero); end
        n_checks++; if (wb_data !== 32'h0080_0000)  begin n_fail++; $display("FAIL zero_denorm_edge_data got=%h exp=00800000", wb_data); end
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL zero_end_valid got=%b exp=0", wb_valid); end
    endtask

    task automatic test_flush_reset();
        int bad;
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_y = $urandom; in_rd = TAG_W'(10 + i); tick();
        end
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        flush = 1'b1; in_rd = 5'd20; wb_ready = 1'b1; #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        n_checks++; if (count !== 3'd0)    begin n_fail++; $display("FAIL flush_count got=%0d exp=0", count); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wb_valid got=%b exp=0", wb_valid); end
        bad = 0;
        for (int t = 0; t < 32; t++) begin
            query_rd = TAG_W'(t); #1;
            if (query_hit !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL flush_query_hits got=%0d exp=0", bad); end
        wb_ready = 1'b0;
        in_valid = 1'b1; in_y = 32'hAAAA_0001; in_rd = 5'd4; tick();
        in_y = 32'hAAAA_0002; in_rd = 5'd5; tick();
        in_valid = 1'b0;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL refill_count got=%0d exp=2", count); end
        rstn = 1'b0; wb_ready = 1'b1;
        tick();
        n_checks++; if (count !== 3'd0)    begin n_fail++; $display("FAIL midreset_count got=%0d exp=0", count); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_wb_valid got=%b exp=0", wb_valid); end
        rstn = 1'b1;
        in_valid = 1'b1; in_y = 32'hC0A0_0000; in_rd = 5'd31; tick();
        in_valid = 1'b0;
        n_checks++; if (wb_data !== 32'hC0A0_0000) begin n_fail++; $display("FAIL post_reset_data got=%h exp=c0a00000", wb_data); end
        n_checks++; if (wb_rd !== 5'd31)           begin n_fail++; $display("FAIL post_reset_rd got=%0d exp=31", wb_rd); end
        tick();
    endtask

    task automatic test_random();
        int sz;
        bit hold;
        bit acc;
        bit ehit;
        logic [31:0]      ey;
        logic [TAG_W-1:0] er;
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            flush    = ($urandom_range(0, 31) == 0);
            wb_ready = ($urandom_range(0, 2) != 0);
            query_rd = TAG_W'($urandom_range(0, 7));
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_y     = ($urandom_range(0, 5) == 0) ? {$urandom_range(0, 1) == 1, 31'd0} : $urandom;
                in_rd    = TAG_W'($urandom_range(0, 7));
            end
            #1;
            sz = mq_y.size();
            ey = (sz != 0) ? mq_y[0]  : 32'd0;
            er = (sz != 0) ? mq_rd[0] : '0;
            ehit = 1'b0;
            foreach (mq_rd[j]) if (mq_rd[j] == query_rd) ehit = 1'b1;
            n_checks++; if (count !== CW'(sz))            begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", c, count, sz); end
            n_checks++; if (wb_valid !== (sz != 0))        begin n_fail++; $display("FAIL rnd_wb_valid[%0d] got=%b exp=%b", c, wb_valid, sz != 0); end
            n_checks++; if (in_ready !== (sz != DEPTH))    begin n_fail++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", c, in_ready, sz != DEPTH); end
            n_checks++; if (wb_data !== ey)                begin n_fail++; $display("FAIL rnd_wb_data[%0d] got=%h exp=%h", c, wb_data, ey); end
            n_checks++; if (wb_rd !== er)                  begin n_fail++; $display("FAIL rnd_wb_rd[%0d] got=%0d exp=%0d", c, wb_rd, er); end
            n_checks++; if (wb_zero !== ((sz != 0) && (ey[30:0] == 31'd0))) begin n_fail++; $display("FAIL rnd_wb_zero[%0d] got=%b data=%h", c, wb_zero, ey); end
            n_checks++; if (query_hit !== ehit)            begin n_fail++; $display("FAIL rnd_query_hit[%0d] got=%b exp=%b rd=%0d", c, query_hit, ehit, query_rd); end
            acc  = in_valid && !flush && (sz != DEPTH);
            hold = in_valid && !acc;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_y = '0; in_rd = '0;
        wb_ready = 1'b0; query_rd = '0;
        test_reset();
        test_fill_backpressure();
        test_back_to_back_wrap();
        test_hazard();
        test_zero();
        test_flush_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
